// File: rtl/two_sum_scanner_if.sv
// Stream, result and cache-side signals of the two-sum scanner.
// The master modport is the scanner; slave is the stream source, result sink and cache.
interface two_sum_scanner_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned COUNT_WIDTH = 8
);
  localparam int unsigned ValW = INDEX_WIDTH + DATA_WIDTH;

  logic                   start;
  logic [DATA_WIDTH-1:0]  target;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_found;
  logic                   out_overflow;
  logic [INDEX_WIDTH-1:0] out_idx0;
  logic [INDEX_WIDTH-1:0] out_idx1;
  logic [COUNT_WIDTH-1:0] collision_count;
  logic [DATA_WIDTH-1:0]  cache_write_key;
  logic [ValW-1:0]        cache_write_value;
  logic                   cache_write_request;
  logic                   cache_collision;
  logic [DATA_WIDTH-1:0]  cache_read_key;
  logic [ValW-1:0]        cache_read_value;
  logic                   cache_read_response;
  logic                   cache_clear;

  modport master (
    input  start, target, in_data, in_valid, in_last, out_ready,
           cache_collision, cache_read_value, cache_read_response,
    output in_ready, out_valid, out_found, out_overflow, out_idx0, out_idx1,
           collision_count, cache_write_key, cache_write_value,
           cache_write_request, cache_read_key, cache_clear
  );

  modport slave (
    output start, target, in_data, in_valid, in_last, out_ready,
           cache_collision, cache_read_value, cache_read_response,
    input  in_ready, out_valid, out_found, out_overflow, out_idx0, out_idx1,
           collision_count, cache_write_key, cache_write_value,
           cache_write_request, cache_read_key, cache_clear
  );
endinterface

// File: rtl/two_sum_scanner.sv
// Streaming two-sum front-end: looks up (target - element) in an external
// direct-mapped cache, reports the index pair on a verified hit, else stores the element.
module two_sum_scanner #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  two_sum_scanner_if.master bus
);
  localparam int unsigned ValW = INDEX_WIDTH + DATA_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] IdxMax = '1;
  localparam logic [COUNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SCAN, S_DRAIN, S_RESULT
  } state_e;

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  target_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic                   found_q;
  logic                   ovf_q;
  logic [INDEX_WIDTH-1:0] idx0_q;
  logic [INDEX_WIDTH-1:0] idx1_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   clear_q;

  logic [DATA_WIDTH-1:0]  read_key_c;
  logic                   hit_c;
  logic                   accept_c;
  logic                   scan_acc_c;

  // A slot hit only counts when the stored number really is the complement.
  assign read_key_c = target_q - bus.in_data;
  assign hit_c      = bus.cache_read_response &&
                      (bus.cache_read_value[DATA_WIDTH-1:0] == read_key_c);
  assign accept_c   = bus.in_valid && in_ready_q;
  assign scan_acc_c = accept_c && (state_q == S_SCAN);

  assign bus.in_ready            = in_ready_q;
  assign bus.out_valid           = out_valid_q;
  assign bus.out_found           = found_q;
  assign bus.out_overflow        = ovf_q;
  assign bus.out_idx0            = idx0_q;
  assign bus.out_idx1            = idx1_q;
  assign bus.collision_count     = cnt_q;
  assign bus.cache_write_key     = bus.in_data;
  assign bus.cache_write_value   = {idx_q, bus.in_data};
  assign bus.cache_write_request = scan_acc_c && !hit_c;
  assign bus.cache_read_key      = read_key_c;
  assign bus.cache_clear         = clear_q;

  // Control FSM; in_ready/out_valid/cache_clear are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      found_q     <= 1'b0;
      ovf_q       <= 1'b0;
      idx0_q      <= '0;
      idx1_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            target_q <= bus.target;
            idx_q    <= '0;
            cnt_q    <= '0;
            found_q  <= 1'b0;
            ovf_q    <= 1'b0;
            idx0_q   <= '0;
            idx1_q   <= '0;
            clear_q  <= 1'b1;
            state_q  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          clear_q    <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= S_SCAN;
        end
        S_SCAN: begin
          if (accept_c) begin
            if (hit_c) begin
              found_q <= 1'b1;
              idx0_q  <= bus.cache_read_value[ValW-1:DATA_WIDTH];
              idx1_q  <= idx_q;
            end else if (bus.cache_collision && (cnt_q != CntMax)) begin
              cnt_q <= cnt_q + COUNT_WIDTH'(1);
            end
            // in_last wins over both the hit-drain and the overflow paths
            if (bus.in_last) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_RESULT;
            end else if (hit_c) begin
              state_q <= S_DRAIN;
            end else if (idx_q == IdxMax) begin
              ovf_q   <= 1'b1;
              state_q <= S_DRAIN;
            end else begin
              idx_q <= idx_q + INDEX_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if (accept_c && bus.in_last) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          clear_q     <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_two_sum_scanner.sv
// Randomised and directed bench for two_sum_scanner with a 4-slot direct-mapped cache
// and a dictionary-style reference of the two-sum query.
module tb_two_sum_scanner;
  localparam int unsigned DW    = 8;
  localparam int unsigned IW    = 2;
  localparam int unsigned CW    = 1;
  localparam int unsigned VW    = IW + DW;
  localparam int          SLOTS = 4;
  localparam int          NMAX  = 1 << IW;
  localparam int          CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  two_sum_scanner_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .COUNT_WIDTH(CW)) bus ();

  two_sum_scanner #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  // External cache: combinational read, write/clear at the clock edge.
  logic          c_valid [SLOTS] = '{default: 1'b0};
  logic [VW-1:0] c_val   [SLOTS] = '{default: '0};
  int            wr_total = 0;
  logic [1:0]    rd_slot;
  logic [1:0]    wr_slot;

  assign rd_slot                 = bus.cache_read_key[1:0];
  assign wr_slot                 = bus.cache_write_key[1:0];
  assign bus.cache_read_response = c_valid[rd_slot];
  assign bus.cache_read_value    = c_val[rd_slot];
  assign bus.cache_collision     = c_valid[wr_slot];

  always @(posedge clk) begin
    if (bus.cache_clear) begin
      for (int i = 0; i < SLOTS; i++) c_valid[i] <= 1'b0;
    end else if (bus.cache_write_request) begin
      c_valid[wr_slot] <= 1'b1;
      c_val[wr_slot]   <= bus.cache_write_value;
      wr_total         <= wr_total + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: scan elements in order against a direct-mapped dictionary.
  function automatic void model(input logic [7:0] t, input logic [7:0] e[$],
                                output bit found, output bit ovf,
                                output int i0, output int i1, output int cnt, output int wr);
    bit         v[SLOTS];
    int         sidx[SLOTS];
    logic [7:0] snum[SLOTS];
    logic [7:0] compl;
    int         s;
    found = 0; ovf = 0; i0 = 0; i1 = 0; cnt = 0; wr = 0;
    for (int k = 0; k < SLOTS; k++) begin v[k] = 0; sidx[k] = 0; snum[k] = '0; end
    for (int i = 0; i < e.size(); i++) begin
      compl = t - e[i];
      s = int'(compl) % SLOTS;
      if (v[s] && snum[s] == compl) begin
        found = 1; i0 = sidx[s]; i1 = i;
        return;
      end
      s = int'(e[i]) % SLOTS;
      if (v[s] && cnt < CMAX) cnt++;
      v[s] = 1; sidx[s] = i; snum[s] = e[i];
      wr++;
      if (i == e.size() - 1) return;
      if (i == NMAX - 1) begin ovf = 1; return; end
    end
  endfunction

  task automatic drive_stream(input logic [7:0] e[$], input bit gaps, input bit mark_last);
    int waited;
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = e[i];
      bus.in_last  = mark_last && (i == e.size() - 1);
      waited = 0;
      while (!bus.in_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.in_ready) begin
        check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input bit f, input bit o,
                              input int i0, input int i1, input int c);
    check({tag, ".found"}, 32'(bus.out_found), 32'(f));
    check({tag, ".ovf"},   32'(bus.out_overflow), 32'(o));
    check({tag, ".idx0"},  32'(bus.out_idx0), 32'(i0));
    check({tag, ".idx1"},  32'(bus.out_idx1), 32'(i1));
    check({tag, ".coll"},  32'(bus.collision_count), 32'(c));
  endtask

  task automatic run_query(input string tag, input logic [7:0] t, input logic [7:0] e[$],
                           input int hold, input bit gaps);
    bit f, o;
    int i0, i1, c, w, w0;
    model(t, e, f, o, i0, i1, c, w);
    @(negedge clk);
    w0 = wr_total;
    bus.start  = 1'b1;
    bus.target = t;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.target = 8'($urandom);
    drive_stream(e, gaps, 1'b1);
    // one negedge after the final accept: result must already be up
    check({tag, ".latency"}, 32'(bus.out_valid), 32'd1);
    for (int h = 0; h < hold; h++) begin
      check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check_result({tag, ".hold"}, f, o, i0, i1, c);
      @(negedge clk);
    end
    check_result(tag, f, o, i0, i1, c);
    check({tag, ".writes"}, 32'(wr_total - w0), 32'(w));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ".released"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".persist"}, 32'(bus.out_found), 32'(f));
  endtask

  initial begin
    logic [7:0] q[$];
    int n;
    bus.start     = 1'b0;
    bus.target    = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.clear", 32'(bus.cache_clear), 32'd0);
    check("rst.wreq", 32'(bus.cache_write_request), 32'd0);
    check_result("rst", 1'b0, 1'b0, 0, 0, 0);
    rst_n = 1'b1;

    run_query("t1_basic",  8'd9,   '{8'd2, 8'd7, 8'd11, 8'd15}, 0, 1'b0);
    run_query("t2_dup",    8'd6,   '{8'd3, 8'd3}, 0, 1'b0);
    run_query("t3_miss",   8'd100, '{8'd1, 8'd2, 8'd3}, 0, 1'b0);
    run_query("t4_false",  8'd10,  '{8'd1, 8'd5, 8'd2}, 0, 1'b0);
    run_query("t5_wrap",   8'hFE,  '{8'h05, 8'hF9}, 0, 1'b0);
    run_query("t6_ovf",    8'd200, '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 3, 1'b0);
    run_query("t7_sat",    8'd100, '{8'd0, 8'd4, 8'd8}, 1, 1'b0);
    run_query("t8_lastmax", 8'd200, '{8'd1, 8'd2, 8'd3, 8'd4}, 0, 1'b0);

    // Abort mid-scan, then confirm stale cache contents are wiped by the next query.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.target = 8'd100;
    @(negedge clk);
    bus.start = 1'b0;
    drive_stream('{8'd4, 8'd8}, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd12;
    #1;
    check("abort.pre_coll", 32'(bus.collision_count), 32'd1);
    check("abort.pre_wreq", 32'(bus.cache_write_request), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort.in_ready", 32'(bus.in_ready), 32'd0);
    check("abort.wreq", 32'(bus.cache_write_request), 32'd0);
    check("abort.out_valid", 32'(bus.out_valid), 32'd0);
    check("abort.clear", 32'(bus.cache_clear), 32'd0);
    check("abort.coll", 32'(bus.collision_count), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_query("t9_reclear", 8'd16, '{8'd8}, 0, 1'b0);

    for (int r = 0; r < 60; r++) begin
      q.delete();
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++)
        q.push_back(($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom));
      run_query("rnd", 8'($urandom_range(0, 30)), q, $urandom_range(0, 3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/two_sum_scanner.md
Name: two_sum_scanner

Overview:
- Streaming front-end that answers the "two sum" query over an input number stream, using an external direct-mapped key/value cache as its lookup store.
- For each accepted element it issues a combinational lookup of (target - element).
  - On a verified hit it reports both indices.
  - Otherwise it writes the element into the cache.
- Sits directly upstream of the cache. It drives the cache's write, read-query and clear inputs and consumes its read and collision outputs.

Parameters:
DATA_WIDTH, 8, width of stream elements, target and cache key (two's complement)
INDEX_WIDTH, 4, element index width; max 2^INDEX_WIDTH elements per query
COUNT_WIDTH, 8, width of saturating collision counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin new query; sampled only in IDLE
target  in  DATA_WIDTH  target sum; latched on accepted start
in_data  in  DATA_WIDTH  stream element
in_valid  in  1  element valid
in_last  in  1  final element of stream
in_ready  out  1  element accepted when in_valid && in_ready
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_found  out  1  pair found
out_overflow  out  1  index space exhausted before a pair or in_last
out_idx0  out  INDEX_WIDTH  earlier index of pair
out_idx1  out  INDEX_WIDTH  later index of pair
collision_count  out  COUNT_WIDTH  cache write collisions this query, saturating
cache_write_key  out  DATA_WIDTH  = in_data
cache_write_value  out  INDEX_WIDTH+DATA_WIDTH  = {idx, in_data}
cache_write_request  out  1  write strobe
cache_collision  in  1  write targets an occupied slot
cache_read_key  out  DATA_WIDTH  = target_q - in_data (mod 2^DATA_WIDTH)
cache_read_value  in  INDEX_WIDTH+DATA_WIDTH  stored {idx, number}; combinational
cache_read_response  in  1  slot valid; combinational
cache_clear  out  1  one-cycle cache invalidate

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, idx=0, target_q=0, collision_count=0.
  - All result registers 0.
  - Every output deasserted: in_ready, out_valid, cache_write_request, cache_clear.
- States IDLE, CLEAR, SCAN, DRAIN, RESULT.
- IDLE: in_ready=0. On start: latch target, idx<=0, collision_count<=0, result regs<=0, then go to CLEAR. start is ignored in all other states.
- CLEAR: cache_clear=1 for exactly one cycle, in_ready=0. Next state is SCAN.
- SCAN: in_ready=1.
  - Hit check, combinational in the accept cycle: hit = cache_read_response && cache_read_value[DATA_WIDTH-1:0] == cache_read_key. A response whose stored number mismatches is a false hit and is treated as a miss.
  - Accept with hit: out_found<=1, out_idx0<=stored idx, out_idx1<=idx, no cache write. Next state is RESULT if in_last, else DRAIN.
  - Accept with miss: cache_write_request=1 in the same cycle. If cache_collision, collision_count increments, saturating at all-ones.
    - in_last: next state RESULT with found=0.
    - else if idx == 2^INDEX_WIDTH-1: out_overflow<=1, next state DRAIN.
    - else idx<=idx+1.
- Self-match is impossible: a write lands at the clock edge, so element i is visible to element i+1 onward, never to itself.
- cache_write_request is never asserted outside an accepting SCAN cycle.
- DRAIN: in_ready=1. Elements are discarded with no cache traffic. The accept of in_last moves to RESULT.
- RESULT: out_valid=1, in_ready=0. All out_* fields are held stable until out_ready; then next state is IDLE. Result fields persist until the next start.
- Result latency: out_valid rises the cycle after the accept of the deciding element, when that element carries in_last.
- Async reset during any state aborts the query. The cache is re-cleared by the next CLEAR state.

Test Plan:
1. target=9, stream 2,7,11,15 (last on 15), out_ready=1:
   - hit on the accept of 7; 11 and 15 drained without writes.
   - out_found=1, idx0=0, idx1=1, collision_count=0.
2. target=6, stream 3,3 (last):
   - the duplicate key matches the earlier entry.
   - out_found=1, idx0=0, idx1=1.
3. target=100, stream 1,2,3 (last on 3):
   - out_found=0, out_overflow=0, exactly three cache writes.
4. Cache of 4 slots, target=10, stream 1,5,... (5 not last):
   - key 5 maps to the slot holding 1; the stored number 1 differs from the complement, so this is a false hit and is rejected.
   - 5 is written, a collision is signalled, collision_count=1.
5. DATA_WIDTH=8, target=0xFE, stream 0x05, 0xF9 (last):
   - the complement 0x05 wraps correctly.
   - out_found=1, idx0=0, idx1=1.
6. INDEX_WIDTH=2, 6 distinct non-matching elements (last on 6th):
   - overflow at idx 3, remaining elements drained.
   - out_overflow=1, out_found=0.
   - out_ready held low 3 cycles: fields stable, then IDLE.
   - Separately, rst_n low mid-SCAN: all outputs 0 immediately.
